ysyx_22041207_fetch_queue: RTL and testbench

YSYX_22041207_FETCH_QUEUE -- requirements
Module: ysyx_22041207_fetch_queue

---
 rtl/ysyx_22041207_fetch_queue_pkg.sv | 23 ++
 rtl/ysyx_22041207_fetch_queue_sync_fifo.sv | 78 +++++++
 rtl/ysyx_22041207_fetch_queue.sv | 140 ++++++++++++++
 tb/tb_ysyx_22041207_fetch_queue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ysyx_22041207_fetch_queue_pkg;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_ADDR = 2'd1,
    FQ_DATA = 2'd2
  } fq_state_e;

  localparam logic [7:0]  RX_SIZE          = 8'b0000_1111;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  // Pick the 32-bit instruction lane out of a 64-bit read word.
  function automatic logic [31:0] select_lane(input logic [63:0] data, input logic hi);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22041207_fetch_queue_sync_fifo.sv
// Synchronous FIFO with wrapping pointers, occupancy counter and flush.
module ysyx_22041207_sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push_en;
  logic             pop_en;

  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  assign pop_en    = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign push_en   = push && (!full || pop_en);
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; flush overrides everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
        2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_22041207_fetch_queue.sv
// Instruction fetch front end: one outstanding read, results queued for decode.
//
// state   | meaning
// --------+---------------------------------------------------------------
// FQ_IDLE | no read in flight; issue when the FIFO has a free slot
// FQ_ADDR | read address presented, waiting for rx_r_ready_o
// FQ_DATA | address accepted, waiting for rx_data_valid
module ysyx_22041207_fetch_queue
  import ysyx_22041207_fetch_queue_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 4,
  parameter int          DATA_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  output logic              rx_r_valid_i,
  input  logic              rx_r_ready_o,
  output logic [63:0]       rx_r_addr_i,
  output logic [7:0]        rx_r_size_i,
  input  logic              rx_data_valid,
  output logic              rx_data_ready,
  input  logic [DATA_W-1:0] rx_data_read_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [63:0]       out_pc
);

  fq_state_e   state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic        discard_q, discard_d;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  fq_entry_t   push_entry;
  fq_entry_t   head_entry;
  logic [63:0] rd_data64;
  logic        lane_hi;
  logic [63:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~64'h3;
  assign rd_data64        = 64'(rx_data_read_o);
  // A 32-bit bus always carries the instruction in the low lane.
  assign lane_hi          = (DATA_W == 64) ? req_addr_q[2] : 1'b0;

  assign rx_r_valid_i  = (state_q == FQ_ADDR);
  assign rx_data_ready = (state_q == FQ_DATA);
  assign rx_r_addr_i   = req_addr_q;
  assign rx_r_size_i   = RX_SIZE;

  assign fifo_pop   = out_valid && out_ready;
  assign push_entry = '{pc: req_addr_q, inst: select_lane(rd_data64, lane_hi)};
  assign out_valid  = !fifo_empty;
  assign out_inst   = head_entry.inst;
  assign out_pc     = head_entry.pc;

  // Next-state, pc and discard tracking for the single outstanding read.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    fifo_push  = 1'b0;
    case (state_q)
      FQ_IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_aligned;
        end else if (!fifo_full) begin
          state_d    = FQ_ADDR;
          req_addr_d = pc_q;
        end
      end
      FQ_ADDR: begin
        if (rx_r_ready_o) begin
          state_d = FQ_DATA;
        end
        // The address already on the bus is allowed to complete; its data is dropped.
        if (redirect_valid) begin
          pc_d      = redirect_aligned;
          discard_d = 1'b1;
        end
      end
      FQ_DATA: begin
        if (rx_data_valid) begin
          state_d   = FQ_IDLE;
          discard_d = 1'b0;
          if (redirect_valid) begin
            pc_d = redirect_aligned;
          end else if (!discard_q) begin
            fifo_push = 1'b1;
            pc_d      = pc_q + 64'd4;
          end
        end else if (redirect_valid) begin
          pc_d      = redirect_aligned;
          discard_d = 1'b1;
        end
      end
      default: begin
        state_d = FQ_IDLE;
      end
    endcase
  end

  // Fetch control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FQ_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
    end
  end

  ysyx_22041207_sync_fifo #(
    .WIDTH($bits(fq_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (head_entry)
  );

endmodule

// File: tb/tb_ysyx_22041207_fetch_queue.sv
// Scoreboard bench for the fetch queue: a negedge monitor models pc, discard and FIFO contents.
module tb_ysyx_22041207_fetch_queue;

  localparam logic [63:0] RST_PC    = 64'h0000_0000_8000_0000;
  localparam logic [63:0] CONST_WORD = 64'hAAAA_BBBB_1111_2222;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        rx_r_valid_i;
  logic        rx_r_ready_o = 1'b0;
  logic [63:0] rx_r_addr_i;
  logic [7:0]  rx_r_size_i;
  logic        rx_data_valid = 1'b0;
  logic        rx_data_ready;
  logic [63:0] rx_data_read_o;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [63:0] out_pc;

  logic        const_mode = 1'b1;
  logic [63:0] tb_addr = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;

  exp_t        expq[$];
  logic [63:0] m_pc = RST_PC;
  logic [63:0] m_req = '0;
  logic        m_discard = 1'b0;
  logic        m_in_addr = 1'b0;

  always #5 clk = ~clk;

  ysyx_22041207_fetch_queue #(
    .RESET_PC (RST_PC),
    .DEPTH    (4),
    .DATA_W   (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rx_r_valid_i   (rx_r_valid_i),
    .rx_r_ready_o   (rx_r_ready_o),
    .rx_r_addr_i    (rx_r_addr_i),
    .rx_r_size_i    (rx_r_size_i),
    .rx_data_valid  (rx_data_valid),
    .rx_data_ready  (rx_data_ready),
    .rx_data_read_o (rx_data_read_o),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  function automatic logic [63:0] word_of(input logic [63:0] a);
    return {a[31:0] ^ 32'h2468_ACE0, a[31:0] ^ 32'h1357_9BDF};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] a, input logic cm);
    logic [63:0] w;
    w = cm ? CONST_WORD : word_of(a);
    return a[2] ? w[63:32] : w[31:0];
  endfunction

  assign rx_data_read_o = const_mode ? CONST_WORD : word_of(tb_addr);

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor/model: decides at negedge what the next posedge will do.
  initial begin : monitor
    exp_t e;
    logic data_hs;
    logic addr_hs;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        m_pc      = RST_PC;
        m_discard = 1'b0;
        m_in_addr = 1'b0;
        req_cnt   = 0;
      end else begin
        check_eq("out_valid", 64'(out_valid), 64'(expq.size() != 0));
        data_hs = rx_data_valid && rx_data_ready;
        addr_hs = rx_r_valid_i && rx_r_ready_o;
        if (out_valid && out_ready && expq.size() != 0) begin
          e = expq.pop_front();
          check_eq("out_pc", out_pc, e.pc);
          check_eq("out_inst", 64'(out_inst), 64'(e.inst));
        end
        if (rx_r_valid_i) begin
          if (!m_in_addr) begin
            check_eq("req_addr", rx_r_addr_i, m_pc);
            m_req = m_pc;
          end else begin
            check_eq("req_hold", rx_r_addr_i, m_req);
          end
        end
        m_in_addr = rx_r_valid_i && !addr_hs;
        if (addr_hs) begin
          req_cnt++;
          tb_addr = rx_r_addr_i;
        end
        if (data_hs) begin
          if (!m_discard && !redirect_valid) begin
            e.pc   = m_req;
            e.inst = exp_inst(m_req, const_mode);
            expq.push_back(e);
            m_pc = m_pc + 64'd4;
          end
          m_discard = 1'b0;
        end
        if (redirect_valid) begin
          expq.delete();
          m_pc = redirect_pc & ~64'h3;
          if ((rx_r_valid_i || rx_data_ready) && !data_hs) m_discard = 1'b1;
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_rvalid", 64'(rx_r_valid_i), 64'd0);
    check_eq("rst_dready", 64'(rx_data_ready), 64'd0);
    check_eq("rst_addr", rx_r_addr_i, 64'd0);
    check_eq("rst_ovalid", 64'(out_valid), 64'd0);
    check_eq("rst_oinst", 64'(out_inst), 64'd0);
    check_eq("rst_opc", out_pc, 64'd0);
    step(2);
    rst = 1'b0;
  endtask

  initial begin : stim
    // Power-on reset with 0-wait memory and a draining consumer.
    rx_r_ready_o  = 1'b1;
    rx_data_valid = 1'b1;
    out_ready     = 1'b1;
    apply_reset();
    check_eq("rx_size", 64'(rx_r_size_i), 64'h0F);

    // First two instructions from the constant memory word.
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    check_eq("first_valid", 64'(out_valid), 64'd1);
    check_eq("first_pc", out_pc, 64'h8000_0000);
    check_eq("first_inst", 64'(out_inst), 64'h1111_2222);
    @(negedge clk);
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    check_eq("second_pc", out_pc, 64'h8000_0004);
    check_eq("second_inst", 64'(out_inst), 64'hAAAA_BBBB);
    step(10);

    // Back-pressure: exactly DEPTH requests, then one per pop.
    const_mode = 1'b0;
    out_ready  = 1'b0;
    apply_reset();
    step(40);
    check_eq("full_reqs", 64'(req_cnt), 64'd4);
    check_eq("full_no_req", 64'(rx_r_valid_i), 64'd0);
    check_eq("full_ovalid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(20);
    check_eq("pop_one_req", 64'(req_cnt), 64'd5);
    check_eq("pop_no_req", 64'(rx_r_valid_i), 64'd0);

    // Redirect while waiting for data: response dropped, new target fetched.
    out_ready     = 1'b1;
    rx_data_valid = 1'b0;
    for (int k = 0; k < 50 && !rx_data_ready; k++) @(negedge clk);
    check_eq("wait_data", 64'(rx_data_ready), 64'd1);
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    step(1);
    redirect_valid = 1'b0;
    step(2);
    rx_data_valid = 1'b1;
    for (int k = 0; k < 50 && !rx_r_valid_i; k++) @(negedge clk);
    check_eq("redir_req_valid", 64'(rx_r_valid_i), 64'd1);
    check_eq("redir_req_addr", rx_r_addr_i, 64'h8000_1000);
    step(10);

    // Redirect coinciding with data handshake and pop.
    out_ready = 1'b0;
    for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
    check_eq("hold_ovalid", 64'(out_valid), 64'd1);
    step(1);
    rx_data_valid = 1'b0;
    for (int k = 0; k < 50 && !rx_data_ready; k++) @(negedge clk);
    check_eq("wait_data2", 64'(rx_data_ready), 64'd1);
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2003;
    rx_data_valid  = 1'b1;
    out_ready      = 1'b1;
    step(1);
    redirect_valid = 1'b0;
    check_eq("flush_pop_ovalid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 50 && !rx_r_valid_i; k++) @(negedge clk);
    check_eq("flush_req_addr", rx_r_addr_i, 64'h8000_2000);
    step(10);

    // Random traffic with wait states, back-pressure and redirects.
    for (int c = 0; c < 1500; c++) begin
      rx_r_ready_o   = ($urandom_range(0, 3) != 0);
      rx_data_valid  = ($urandom_range(0, 2) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = 64'h8000_0000 + 64'($urandom_range(0, 16383));
      step(1);
    end
    redirect_valid = 1'b0;

    // Asynchronous reset while stuck in ADDR.
    rx_r_ready_o  = 1'b0;
    rx_data_valid = 1'b1;
    out_ready     = 1'b1;
    for (int k = 0; k < 50 && !rx_r_valid_i; k++) @(negedge clk);
    check_eq("stuck_addr", 64'(rx_r_valid_i), 64'd1);
    apply_reset();
    rx_r_ready_o = 1'b1;
    for (int k = 0; k < 50 && !rx_r_valid_i; k++) @(negedge clk);
    check_eq("post_rst_addr", rx_r_addr_i, 64'h8000_0000);
    step(30);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
